mem_bus_bridge: RTL and testbench

MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

---
 rtl/mem_bus_bridge.sv | 169 ++++++++++++++++
 tb/tb_mem_bus_bridge.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
// Bridges a multiplexed address/data CPU bus onto a simple request/ready
// memory port. The FSM has four states:
//   IDLE  - waiting for an address phase.
//   ARMED - an address has been latched; waiting for a read or write strobe.
//   REQ   - an access is in flight and the CPU is stalled.
//   HOLD  - the access is done; waiting for the CPU to release nME.
// Every output is driven directly from a flop.
//
// Ports
//   Clock, Reset          : single clock; synchronous active-high reset
//   Data_out[15:0]        : CPU multiplexed address/data bus
//   ALE, nME, nOE, RnW    : CPU address latch, memory enable, read strobe, direction
//   Data_in[15:0]         : registered read data back to the CPU
//   nWait                 : active-low CPU stall
//   MemAddr, MemWData     : registered address and write data to memory
//   MemRe, MemWe          : one-cycle read and write request pulses
//   MemRData, MemReady    : memory read data and completion
//   BusErr                : one-cycle pulse when an access completes on timeout
module mem_bus_bridge #(
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Data_out,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        RnW,
  output logic [15:0] Data_in,
  output logic        nWait,
  output logic [15:0] MemAddr,
  output logic [15:0] MemWData,
  output logic        MemRe,
  output logic        MemWe,
  input  logic [15:0] MemRData,
  input  logic        MemReady,
  output logic        BusErr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] REQ   = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [7:0] WAIT_C    = 8'(WAIT_CYCLES);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] din_q, din_d;
  logic        nwait_q, nwait_d;
  logic        re_q, re_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  // Direction of the access in flight. The CPU may change RnW during REQ,
  // so the direction is captured when the request is issued.
  logic        rnw_q, rnw_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    nwait_d = nwait_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    rnw_d   = rnw_q;

    case (state_q)
      IDLE: begin
        if (ALE) begin
          addr_d  = Data_out;
          state_d = ARMED;
        end
      end

      ARMED: begin
        // A new address phase takes priority over any strobe in the same cycle.
        if (ALE) begin
          addr_d = Data_out;
        end else if (!nME && !RnW) begin
          wdata_d = Data_out;
          we_d    = 1'b1;
          nwait_d = 1'b0;
          cnt_d   = 8'd0;
          rnw_d   = 1'b0;
          state_d = REQ;
        end else if (!nME && RnW && !nOE) begin
          re_d    = 1'b1;
          nwait_d = 1'b0;
          cnt_d   = 8'd0;
          rnw_d   = 1'b1;
          state_d = REQ;
        end
      end

      REQ: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // A ready memory wins over a timeout on the same edge.
        if (cnt_q >= WAIT_C && MemReady) begin
          if (rnw_q) din_d = MemRData;
          nwait_d = 1'b1;
          state_d = HOLD;
        end else if (cnt_q >= TIMEOUT_C) begin
          if (rnw_q) din_d = 16'hDEAD;
          err_d   = 1'b1;
          nwait_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Stay here while nME is low, so that a second access
        // needs a fresh address phase.
        if (nME) begin
          if (ALE) begin
            addr_d  = Data_out;
            state_d = ARMED;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      din_q   <= 16'h0000;
      nwait_q <= 1'b1;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      rnw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      nwait_q <= nwait_d;
      re_q    <= re_d;
      we_q    <= we_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rnw_q   <= rnw_d;
    end
  end

  assign Data_in  = din_q;
  assign nWait    = nwait_q;
  assign MemAddr  = addr_q;
  assign MemWData = wdata_q;
  assign MemRe    = re_q;
  assign MemWe    = we_q;
  assign BusErr   = err_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge. Two instances share the CPU-side inputs:
//   u1: WAIT_CYCLES=1, TIMEOUT=255
//   u3: WAIT_CYCLES=3, TIMEOUT=8
// Each instance has its own MemReady. When an access is issued, the expected
// result is pushed into a scoreboard queue. It is popped and compared when the
// selected instance raises nWait again.
module tb_mem_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_out;
  logic        ale, nme, noe, rnw;
  logic [15:0] mem_rdata;
  logic        ready1, ready3;

  logic [15:0] din1, addr1, wdata1, din3, addr3, wdata3;
  logic        nwait1, re1, we1, err1, nwait3, re3, we3, err3;

  always #5 clk = ~clk;

  mem_bus_bridge #(.WAIT_CYCLES(1), .TIMEOUT(255)) u1 (
    .Clock(clk), .Reset(rst), .Data_out(data_out), .ALE(ale), .nME(nme),
    .nOE(noe), .RnW(rnw), .Data_in(din1), .nWait(nwait1), .MemAddr(addr1),
    .MemWData(wdata1), .MemRe(re1), .MemWe(we1), .MemRData(mem_rdata),
    .MemReady(ready1), .BusErr(err1)
  );

  mem_bus_bridge #(.WAIT_CYCLES(3), .TIMEOUT(8)) u3 (
    .Clock(clk), .Reset(rst), .Data_out(data_out), .ALE(ale), .nME(nme),
    .nOE(noe), .RnW(rnw), .Data_in(din3), .nWait(nwait3), .MemAddr(addr3),
    .MemWData(wdata3), .MemRe(re3), .MemWe(we3), .MemRData(mem_rdata),
    .MemReady(ready3), .BusErr(err3)
  );

  // View of the instance under test.
  logic        sel;
  logic [15:0] o_din, o_addr, o_wdata;
  logic        o_nwait, o_re, o_we, o_err;
  always_comb begin
    o_din   = sel ? din3   : din1;
    o_addr  = sel ? addr3  : addr1;
    o_wdata = sel ? wdata3 : wdata1;
    o_nwait = sel ? nwait3 : nwait1;
    o_re    = sel ? re3    : re1;
    o_we    = sel ? we3    : we1;
    o_err   = sel ? err3   : err1;
  end

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    int          nwait_low;
    int          err_n;
    int          re_n;
    int          we_n;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_din[2];
  logic [15:0] last_wdata[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ready(input bit s, input logic v);
    if (s) ready3 = v; else ready1 = v;
  endtask

  // Runs one access on instance s.
  // The memory holds MemReady low for low_n REQ edges, then raises it.
  // If dbl is set, a preceding address phase (16'h0010) is followed by
  // a second ALE that coincides with a read strobe.
  task automatic do_access(input string name, input bit s, input bit is_rd,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdata, input int low_n, input bit dbl);
    int   w, t, j, low, re_n, we_n, err_n;
    bit   timed, done;
    logic [15:0] addr_seen, wdata_seen, din_seen;
    exp_t e, g;

    sel = s;
    w = s ? 3 : 1;
    t = s ? 8 : 255;
    ready1 = 1'b1;
    ready3 = 1'b1;
    mem_rdata = rdata;

    // Address phase.
    ale = 1'b1; nme = 1'b1; noe = 1'b1; rnw = 1'b1;
    data_out = dbl ? 16'h0010 : addr;
    @(negedge clk);
    if (dbl) begin
      ale = 1'b1; nme = 1'b0; noe = 1'b0; rnw = 1'b1; data_out = addr;
      @(negedge clk);
      check({name, "_ale_prio_re"}, o_re, 1'b0);
      check({name, "_ale_prio_nwait"}, o_nwait, 1'b1);
    end

    // Reference model: the access completes at the first REQ edge where the
    // counter is at least w and the memory is ready. Otherwise it is forced
    // to complete when the counter reaches t.
    j = (low_n > w) ? low_n : w;
    timed = (j > t);
    if (timed) j = t;
    e.addr      = addr;
    e.wdata     = is_rd ? last_wdata[s] : wdata;
    e.din       = is_rd ? (timed ? 16'hDEAD : rdata) : last_din[s];
    e.nwait_low = j + 1;
    e.err_n     = timed ? 1 : 0;
    e.re_n      = is_rd ? 1 : 0;
    e.we_n      = is_rd ? 0 : 1;
    sb.push_back(e);
    // Both instances see the same traffic.
    // The other instance always has a ready memory.
    if (is_rd) begin
      last_din[s]  = e.din;
      last_din[!s] = rdata;
    end else begin
      last_wdata[0] = wdata;
      last_wdata[1] = wdata;
    end

    // Strobe phase. Data_out is don't-care for reads.
    ale = 1'b0; nme = 1'b0; rnw = is_rd; noe = !is_rd;
    data_out = is_rd ? 16'hFFFF : wdata;
    @(negedge clk);
    addr_seen  = o_addr;
    wdata_seen = o_wdata;
    low = 0; re_n = 0; we_n = 0; err_n = 0; done = 0; din_seen = 16'hxxxx;
    for (int c = 0; c < 400 && !done; c++) begin
      re_n  += int'(o_re);
      we_n  += int'(o_we);
      err_n += int'(o_err);
      if (o_nwait === 1'b0) begin
        low++;
        set_ready(s, (c >= low_n));
        @(negedge clk);
      end else begin
        done = 1;
        din_seen = o_din;
      end
    end
    check({name, "_completed"}, done, 1'b1);

    // Keep nME low for a while. No further request is allowed
    // without a new address phase.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      re_n  += int'(o_re);
      we_n  += int'(o_we);
      err_n += int'(o_err);
    end
    nme = 1'b1; noe = 1'b1; ready1 = 1'b1; ready3 = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20 && !(nwait1 && nwait3); c++) @(negedge clk);
    check({name, "_both_idle"}, {nwait1, nwait3}, 2'b11);

    g = sb.pop_front();
    check({name, "_addr"}, addr_seen, g.addr);
    check({name, "_wdata"}, wdata_seen, g.wdata);
    check({name, "_din"}, din_seen, g.din);
    check({name, "_nwait_low"}, low, g.nwait_low);
    check({name, "_buserr"}, err_n, g.err_n);
    check({name, "_re_pulses"}, re_n, g.re_n);
    check({name, "_we_pulses"}, we_n, g.we_n);
    $display("access %s: dut=%0d addr=%h din=%h nwait_low=%0d buserr=%0d re=%0d we=%0d",
             name, s ? 3 : 1, addr_seen, din_seen, low, err_n, re_n, we_n);
  endtask

  initial begin
    sel = 1'b0;
    rst = 1'b1;
    data_out = 16'h0000; ale = 1'b0; nme = 1'b1; noe = 1'b1; rnw = 1'b1;
    mem_rdata = 16'h0000; ready1 = 1'b1; ready3 = 1'b1;
    last_din = '{16'h0000, 16'h0000};
    last_wdata = '{16'h0000, 16'h0000};
    repeat (2) @(negedge clk);

    check("rst_u1_outputs", {din1, addr1, wdata1, nwait1, re1, we1, err1},
          {48'h0, 4'b1000});
    check("rst_u3_outputs", {din3, addr3, wdata3, nwait3, re3, we3, err3},
          {48'h0, 4'b1000});
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_pulses", {re1, we1, err1, re3, we3, err3}, 6'b0);

    do_access("rd_basic", 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1234, 0, 1'b0);
    do_access("wr_basic", 1'b0, 1'b0, 16'h0100, 16'hBEEF, 16'h0000, 0, 1'b0);
    do_access("rd_wait6", 1'b1, 1'b1, 16'h0200, 16'h0000, 16'h5A5A, 6, 1'b0);
    do_access("rd_timeout", 1'b1, 1'b1, 16'h0204, 16'h0000, 16'h9999, 100, 1'b0);
    do_access("rd_dbl_ale", 1'b0, 1'b1, 16'h0020, 16'h0000, 16'hA5C3, 0, 1'b0 | 1'b1);
    do_access("rd_ready_at_to", 1'b1, 1'b1, 16'h0208, 16'h0000, 16'h3C3C, 8, 1'b0);
    do_access("wr_timeout", 1'b1, 1'b0, 16'h020C, 16'h1357, 16'h0000, 100, 1'b0);

    // Reset in the middle of a stalled read on u3.
    sel = 1'b1;
    ale = 1'b1; nme = 1'b1; data_out = 16'h0300;
    @(negedge clk);
    ale = 1'b0; nme = 1'b0; rnw = 1'b1; noe = 1'b0; ready3 = 1'b0;
    repeat (3) @(negedge clk);
    check("midreq_stalled", nwait3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midreq_rst_u3", {din3, addr3, wdata3, nwait3, re3, we3, err3},
          {48'h0, 4'b1000});
    check("midreq_rst_u1", {din1, nwait1, re1, we1, err1}, {16'h0, 4'b1000});
    rst = 1'b0; nme = 1'b1; noe = 1'b1; ready3 = 1'b1;
    @(negedge clk);
    check("midreq_post_rst_pulses", {re1, we1, err1, re3, we3, err3, nwait3}, 7'b0000001);
    last_din = '{16'h0000, 16'h0000};
    last_wdata = '{16'h0000, 16'h0000};
    do_access("rd_after_rst", 1'b1, 1'b1, 16'h0304, 16'h0000, 16'hC0DE, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
